// File: rtl/latch_wr_sched.sv
// latch_wr_sched: round-robin write scheduler for a shared transparent latch with readback checking.
// Define LATSCHED_CHECK_EN to enable the lat_q readback compare and err/err_cnt reporting.
module latch_wr_sched #(
  parameter int NREQ     = 3,
  parameter int W        = 8,
  parameter int OPEN_CYC = 2,
  parameter int HOLD_CYC = 1,
  parameter int CW       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*W-1:0] wdata_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic              lat_en_o,
  output logic [W-1:0]      lat_d_o,
  input  logic [W-1:0]      lat_q_i,
  output logic              busy_o,
  output logic              err_o,
  output logic [CW-1:0]     err_cnt_o,
  input  logic              err_clr_i
);
  localparam int PW  = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int MC  = OPEN_CYC > HOLD_CYC ? OPEN_CYC : HOLD_CYC;
  localparam int CNW = $clog2(MC + 1);

  typedef enum logic [2:0] {IDLE, GRANT, OPEN, CLOSE, CHECK} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, sel_q, sel_d, win;
  logic [CNW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]    lat_d_q, lat_d_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic            lat_en_q, busy_q;

  // Descending scan so the lowest offset from ptr overwrites the rest.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_i[(int'(ptr_q) + i) % NREQ]) win = PW'((int'(ptr_q) + i) % NREQ);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    lat_d_d = lat_d_q;
    case (state_q)
      IDLE:
        if (|req_i) begin
          state_d = GRANT;
          sel_d   = win;
          lat_d_d = wdata_i[int'(win)*W +: W];
        end
      GRANT: begin
        state_d = OPEN;
        cnt_d   = CNW'(OPEN_CYC - 1);
      end
      OPEN:
        if (cnt_q == '0) begin
          state_d = CLOSE;
          cnt_d   = CNW'(HOLD_CYC - 1);
        end else cnt_d = cnt_q - CNW'(1);
      CLOSE:
        if (cnt_q == '0) state_d = CHECK;
        else cnt_d = cnt_q - CNW'(1);
      CHECK: begin
        state_d = IDLE;
        ptr_d   = (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + PW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // gnt/lat_en/busy track the state being entered; done reports the CHECK just left.
  assign gnt_d  = (state_d == GRANT) ? NREQ'(1) << sel_d : '0;
  assign done_d = (state_q == CHECK) ? NREQ'(1) << sel_q : '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      lat_d_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      lat_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      lat_d_q  <= lat_d_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      lat_en_q <= state_d == OPEN;
      busy_q   <= state_d != IDLE;
    end

`ifdef LATSCHED_CHECK_EN
  logic          err_q, err_d, mism;
  logic [CW-1:0] err_cnt_q, err_cnt_d;

  // A mismatch in the same cycle as err_clr restarts the count at one.
  assign mism      = (state_q == CHECK) && (lat_q_i != lat_d_q);
  assign err_d     = mism | (err_q & ~err_clr_i);
  assign err_cnt_d = mism ? (err_clr_i ? CW'(1) : (&err_cnt_q ? err_cnt_q : err_cnt_q + CW'(1)))
                          : (err_clr_i ? '0 : err_cnt_q);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end

  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;
`else
  logic unused_chk;
  assign unused_chk = ^{lat_q_i, err_clr_i};
  assign err_o      = 1'b0;
  assign err_cnt_o  = '0;
`endif

  assign gnt_o    = gnt_q;
  assign done_o   = done_q;
  assign lat_en_o = lat_en_q;
  assign lat_d_o  = lat_d_q;
  assign busy_o   = busy_q;
endmodule

// File: tb/tb_latch_wr_sched.sv
// tb_latch_wr_sched: directed vector bench for latch_wr_sched with a behavioural latch on lat_q.
module tb_latch_wr_sched;
  localparam int NREQ = 3;
  localparam int W    = 8;
  localparam int CW   = 4;
`ifdef LATSCHED_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] wdata = '0;
  logic              err_clr = 1'b0, bad = 1'b0;
  logic [NREQ-1:0]   gnt, done;
  logic              lat_en, busy, err;
  logic [W-1:0]      lat_d, lat_q, lat_mem;
  logic [CW-1:0]     err_cnt;
  int                pass = 0, total = 0;

  latch_wr_sched dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .wdata_i(wdata), .gnt_o(gnt), .done_o(done),
    .lat_en_o(lat_en), .lat_d_o(lat_d), .lat_q_i(lat_q), .busy_o(busy), .err_o(err),
    .err_cnt_o(err_cnt), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  always_latch if (lat_en) lat_mem <= lat_d;
  assign lat_q = bad ? '0 : lat_mem;

  typedef struct {
    logic [2:0]  req;
    logic [23:0] wd;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic        en;
    logic [7:0]  d;
    logic        busy;
  } vec_t;
  vec_t tv[31];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; err_clr = 1'b0; bad = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      req = tv[i].req;
      wdata = tv[i].wd;
      step();
      chk($sformatf("vec%0d", i), 32'({gnt, done, lat_en, lat_d, busy}),
          32'({tv[i].gnt, tv[i].done, tv[i].en, tv[i].d, tv[i].busy}));
    end
  endtask

  // One write from requester 0; returns after the done cycle.
  task automatic write0(input logic [7:0] dat, input bit clr_at_check);
    req = 3'b001;
    wdata = {16'h0, dat};
    step();
    req = '0;
    for (int c = 0; c < 4; c++) step();
    err_clr = clr_at_check;
    step();
    err_clr = 1'b0;
  endtask

  initial begin
    tv[0] = '{3'b001, 24'h0000A5, 3'b001, 3'b000, 1'b0, 8'hA5, 1'b1};
    tv[1] = '{3'b000, 24'h0000A5, 3'b000, 3'b000, 1'b1, 8'hA5, 1'b1};
    tv[2] = '{3'b000, 24'h0000A5, 3'b000, 3'b000, 1'b1, 8'hA5, 1'b1};
    tv[3] = '{3'b000, 24'h0000A5, 3'b000, 3'b000, 1'b0, 8'hA5, 1'b1};
    tv[4] = '{3'b000, 24'h0000A5, 3'b000, 3'b000, 1'b0, 8'hA5, 1'b1};
    tv[5] = '{3'b000, 24'h0000A5, 3'b000, 3'b001, 1'b0, 8'hA5, 1'b0};
    tv[6] = '{3'b000, 24'h0000A5, 3'b000, 3'b000, 1'b0, 8'hA5, 1'b0};
    for (int w = 0; w < 4; w++)
      for (int c = 0; c < 6; c++) begin
        int s;
        s = w % 3;
        tv[7 + w*6 + c] = '{3'b111, 24'h332211,
                            (c == 0) ? 3'(1 << s) : 3'b000,
                            (c == 5) ? 3'(1 << s) : 3'b000,
                            (c == 1 || c == 2), 8'(8'h11 * (s + 1)), (c < 5)};
      end

    // Reset state, then single write and round-robin sequence.
    step();
    chk("reset", 32'({gnt, done, lat_en, lat_d, busy, err, err_cnt}), 32'h0);
    rst_n = 1'b1;
    run(0, 6);
    chk("s1_err", 32'(err), 32'h0);
    do_reset();
    run(7, 30);

    // Forced readback mismatches; saturation; err_clr colliding with a mismatch.
    do_reset();
    bad = 1'b1;
    for (int k = 0; k < 17; k++) begin
      write0(8'h5A, 1'b0);
      chk($sformatf("s3_done%0d", k), 32'(done), 32'h1);
      if (k == 0) chk("s3_err_first", 32'({err, err_cnt}), 32'({CHK, CW'(CHK)}));
    end
    chk("s3_sat", 32'({err, err_cnt}), CHK ? 32'h1F : 32'h0);
    write0(8'h5A, 1'b1);
    chk("s3_clr_vs_mism", 32'({err, err_cnt}), CHK ? 32'h11 : 32'h0);
    bad = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("s3_clr", 32'({err, err_cnt}), 32'h0);

    // Async reset during OPEN; ptr must return to 0.
    do_reset();
    req = 3'b010;
    step();
    req = '0;
    for (int c = 0; c < 5; c++) step();
    chk("s4_first_done", 32'(done), 32'h2);
    req = 3'b100;
    wdata = 24'hC30000;
    step();
    req = '0;
    step();
    step();
    chk("s4_open", 32'(lat_en), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("s4_async", 32'({lat_en, busy, gnt, done}), 32'h0);
    step();
    chk("s4_nodone", 32'({done, busy}), 32'h0);
    rst_n = 1'b1;
    req = 3'b110;
    step();
    req = '0;
    chk("s4_ptr0", 32'(gnt), 32'h2);
    for (int c = 0; c < 5; c++) step();
    chk("s4_done", 32'(done), 32'h2);

    // Short req pulse during OPEN is ignored; wdata changes do not reach lat_d.
    do_reset();
    req = 3'b001;
    wdata = 24'h000077;
    step();
    req = '0;
    step();
    chk("s5_open", 32'(lat_en), 32'h1);
    req = 3'b100;
    wdata = 24'hEE00FF;
    step();
    req = '0;
    chk("s5_hold", 32'(lat_d), 32'h77);
    for (int c = 0; c < 3; c++) step();
    chk("s5_done", 32'({done, lat_d}), 32'h177);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("s5_idle%0d", c), 32'({gnt, busy}), 32'h0);
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
